// File: rtl/wbm_burst_gen_pkg.sv
// Shared types and helpers for the WISHBONE burst generator: FSM state
// encoding and the deterministic data pattern used for writes and read checks.
package wbm_burst_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_BURST    = 2'd1,
    ST_RTY_WAIT = 2'd2,
    ST_DONE     = 2'd3
  } state_t;

  localparam logic [3:0]  SEL_ALL  = 4'hF;
  localparam logic [15:0] MISM_MAX = 16'hFFFF;

  function automatic logic [31:0] pattern_word(input logic [31:0] seed,
                                               input logic [31:0] idx);
    return seed + idx;
  endfunction

  // Word address; wraps modulo 2^32 with no boundary stop.
  function automatic logic [31:0] word_adr(input logic [31:0] base,
                                           input logic [31:0] idx);
    return base + {idx[29:0], 2'b00};
  endfunction

endpackage

// File: rtl/wbm_burst_gen.sv
// WISHBONE master burst traffic generator with pattern write and read checking.
// One command = one burst; status (mismatch, retry, abort) held for debug.
module wbm_burst_gen
  import wbm_burst_gen_pkg::*;
#(
  parameter int LEN_W   = 8,
  parameter int RTY_GAP = 4,
  parameter int MAX_RTY = 255
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             we_i,
  input  logic [31:0]      base_adr_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic [31:0]      seed_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             abort_o,
  output logic [15:0]      mism_cnt_o,
  output logic [31:0]      first_mism_adr_o,
  output logic [7:0]       rty_cnt_o,
  output logic             wbm_cyc_o,
  output logic             wbm_stb_o,
  output logic             wbm_cab_o,
  output logic             wbm_we_o,
  output logic [31:0]      wbm_adr_o,
  output logic [3:0]       wbm_sel_o,
  output logic [31:0]      wbm_dat_o,
  input  logic [31:0]      wbm_dat_i,
  input  logic             wbm_ack_i,
  input  logic             wbm_rty_i,
  input  logic             wbm_err_i
);

  localparam int              GAP_W     = (RTY_GAP > 1) ? $clog2(RTY_GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(RTY_GAP - 1);
  localparam logic [7:0]      RTY_LIMIT = 8'(MAX_RTY);

  state_t           state_q, state_d;
  logic [31:0]      base_q, base_d;
  logic [31:0]      seed_q, seed_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] idx_q, idx_d;
  logic             we_q, we_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             abort_q, abort_d;
  logic [15:0]      mism_cnt_q, mism_cnt_d;
  logic [31:0]      first_mism_adr_q, first_mism_adr_d;
  logic [7:0]       rty_cnt_q, rty_cnt_d;
  logic             cyc_q, cyc_d;
  logic             cab_q, cab_d;
  logic             bus_we_q, bus_we_d;
  logic [31:0]      adr_q, adr_d;
  logic [3:0]       sel_q, sel_d;
  logic [31:0]      dat_q, dat_d;

  always_comb begin
    state_d          = state_q;
    base_d           = base_q;
    seed_d           = seed_q;
    len_d            = len_q;
    idx_d            = idx_q;
    we_d             = we_q;
    gap_d            = gap_q;
    abort_d          = abort_q;
    mism_cnt_d       = mism_cnt_q;
    first_mism_adr_d = first_mism_adr_q;
    rty_cnt_d        = rty_cnt_q;
    done_d           = 1'b0;
    cyc_d            = 1'b0;
    cab_d            = 1'b0;
    bus_we_d         = 1'b0;
    adr_d            = '0;
    sel_d            = '0;
    dat_d            = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          base_d           = base_adr_i & ~32'h3;
          seed_d           = seed_i;
          len_d            = len_i;
          we_d             = we_i;
          idx_d            = '0;
          abort_d          = 1'b0;
          mism_cnt_d       = '0;
          first_mism_adr_d = '0;
          rty_cnt_d        = '0;
          if (len_i != '0) begin
            state_d = ST_BURST;
            cyc_d   = 1'b1;
          end else begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end
        end
      end

      ST_BURST: begin
        cyc_d = 1'b1;
        // Termination priority: ack over err over rty.
        if (wbm_ack_i) begin
          idx_d = idx_q + 1'b1;
          if (!we_q && (wbm_dat_i != pattern_word(seed_q, 32'(idx_q)))) begin
            if (mism_cnt_q != MISM_MAX) mism_cnt_d = mism_cnt_q + 16'd1;
            if (mism_cnt_q == '0) first_mism_adr_d = adr_q;
          end
          if (idx_d == len_q) begin
            cyc_d   = 1'b0;
            state_d = ST_DONE;
            done_d  = 1'b1;
          end
        end else if (wbm_err_i) begin
          cyc_d   = 1'b0;
          abort_d = 1'b1;
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else if (wbm_rty_i) begin
          cyc_d     = 1'b0;
          rty_cnt_d = rty_cnt_q + 8'd1;
          if (rty_cnt_d == RTY_LIMIT) begin
            abort_d = 1'b1;
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_RTY_WAIT;
            gap_d   = GAP_LOAD;
          end
        end
      end

      ST_RTY_WAIT: begin
        // Last idle cycle re-arms cyc so the bus sees exactly RTY_GAP idle cycles.
        if (gap_q == '0) begin
          state_d = ST_BURST;
          cyc_d   = 1'b1;
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);

    if (cyc_d) begin
      adr_d    = word_adr(base_d, 32'(idx_d));
      dat_d    = pattern_word(seed_d, 32'(idx_d));
      cab_d    = (len_d - idx_d) > LEN_W'(1);
      bus_we_d = we_d;
      sel_d    = SEL_ALL;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q          <= ST_IDLE;
      base_q           <= '0;
      seed_q           <= '0;
      len_q            <= '0;
      idx_q            <= '0;
      we_q             <= 1'b0;
      gap_q            <= '0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      abort_q          <= 1'b0;
      mism_cnt_q       <= '0;
      first_mism_adr_q <= '0;
      rty_cnt_q        <= '0;
      cyc_q            <= 1'b0;
      cab_q            <= 1'b0;
      bus_we_q         <= 1'b0;
      adr_q            <= '0;
      sel_q            <= '0;
      dat_q            <= '0;
    end else begin
      state_q          <= state_d;
      base_q           <= base_d;
      seed_q           <= seed_d;
      len_q            <= len_d;
      idx_q            <= idx_d;
      we_q             <= we_d;
      gap_q            <= gap_d;
      busy_q           <= busy_d;
      done_q           <= done_d;
      abort_q          <= abort_d;
      mism_cnt_q       <= mism_cnt_d;
      first_mism_adr_q <= first_mism_adr_d;
      rty_cnt_q        <= rty_cnt_d;
      cyc_q            <= cyc_d;
      cab_q            <= cab_d;
      bus_we_q         <= bus_we_d;
      adr_q            <= adr_d;
      sel_q            <= sel_d;
      dat_q            <= dat_d;
    end
  end

  assign busy_o           = busy_q;
  assign done_o           = done_q;
  assign abort_o          = abort_q;
  assign mism_cnt_o       = mism_cnt_q;
  assign first_mism_adr_o = first_mism_adr_q;
  assign rty_cnt_o        = rty_cnt_q;
  assign wbm_cyc_o        = cyc_q;
  assign wbm_stb_o        = cyc_q;
  assign wbm_cab_o        = cab_q;
  assign wbm_we_o         = bus_we_q;
  assign wbm_adr_o        = adr_q;
  assign wbm_sel_o        = sel_q;
  assign wbm_dat_o        = dat_q;

endmodule
